oop_dac_ramp: RTL
=================

Name: oop_dac_ramp

Overview:
- Slew-limited setpoint sequencer for the out-of-plane (lid) cathode DAC.
- Accepts a target code from the host register interface, clamps it to safe limits, and ramps its 16-bit output toward the target in programmable steps at a fixed tick rate.
- Its output drives the value input of the OOP DAC serial loader. An emergency-stop input forces the output to a safe code immediately.

Parameters:
- RATE_DIV, 32768, clk48mhz cycles per ramp tick (32768 = one DAC load frame); legal range 2..2^24-1.
- MIN_CODE, 16'h0000, lowest permitted output code.
- MAX_CODE, 16'hFFFF, highest permitted output code.
- SAFE_VALUE, 16'h8000, code forced at reset and during estop; must satisfy MIN_CODE <= SAFE_VALUE <= MAX_CODE.

Ports:
- clk48mhz  input  1  system clock, 48 MHz.
- rstn  input  1  reset, synchronous, active-low.
- target_value  input  16  requested DAC code.
- step_size  input  16  ramp increment per tick; 0 means jump directly to the target.
- target_wr  input  1  single-cycle strobe; latches target_value and step_size.
- estop  input  1  level; forces SAFE state.
- dac_value  output  16  current setpoint, fed to the OOP DAC loader value input.
- busy  output  1  high while dac_value != target register.
- at_target  output  1  high when dac_value == target register and not in SAFE.
- range_err  output  1  sticky flag; set when a write was clamped.

Behaviour:
- Reset is synchronous and active-low on clk48mhz. During rstn=0 and on exit from reset:
  - dac_value = SAFE_VALUE, target_reg = SAFE_VALUE, step_reg = 0.
  - busy = 0, at_target = 1, range_err = 0.
  - Tick counter = 0, state = IDLE.
- States: IDLE, RAMP_UP, RAMP_DOWN, SAFE. All outputs are registered.
- Write acceptance (target_wr=1, estop=0):
  - target_reg <= clamp(target_value, MIN_CODE, MAX_CODE); step_reg <= step_size; tick counter <= 0.
  - range_err <= 1 if clamping occurred, else 0. Any accepted write updates the flag.
  - Next state: RAMP_UP if clamped target > dac_value, RAMP_DOWN if < dac_value, IDLE if equal.
  - No step is applied in the write cycle.
  - If step_size = 0: dac_value <= clamped target at the same edge, state IDLE.
- Tick: the counter increments every cycle while in RAMP_UP or RAMP_DOWN; it holds at 0 in IDLE and SAFE. A tick fires when counter == RATE_DIV-1; the counter then wraps to 0.
- Latency: with a write sampled at edge E0, the first dac_value change occurs at edge E0+RATE_DIV, then every RATE_DIV edges after that.
- Step arithmetic uses 17-bit differences; dac_value never overshoots and never wraps.
  - RAMP_UP: if target_reg - dac_value <= step_reg, dac_value <= target_reg and state IDLE; else dac_value <= dac_value + step_reg.
  - RAMP_DOWN: symmetric; dac_value - target_reg <= step_reg lands exactly on target_reg.
- Retarget mid-ramp: a new write is accepted in any non-SAFE state. Direction is re-evaluated against the current dac_value and the counter restarts. A write in the same cycle as a tick takes priority, and that tick is discarded.
- estop=1:
  - Next edge: state SAFE, dac_value <= SAFE_VALUE, busy = 0, at_target = 0.
  - target_wr is ignored; range_err holds its value.
  - estop has priority over a simultaneous write and over a tick.
- estop falling: next state IDLE with target_reg = SAFE_VALUE, so at_target = 1. Output stays at SAFE_VALUE until a new write.
- busy = (state is RAMP_UP or RAMP_DOWN). at_target = (state == IDLE).
- rstn=0 mid-ramp: immediate return to reset values at the next edge, regardless of estop or target_wr.

Test Plan:
- Reset: hold rstn=0 for 4 cycles, release -> dac_value=0x8000, busy=0, at_target=1, range_err=0, stable over 100 cycles.
- Ramp up with RATE_DIV=4: write target 0x8010, step 4 at E0 -> dac_value 0x8004/0x8008/0x800C/0x8010 at E0+4/+8/+12/+16; busy drops at E0+16.
- Non-multiple step down: from 0x8000, target 0x7FF9, step 4 -> 0x7FFC, then 0x7FF9 (no undershoot); at_target=1.
- Clamp: MAX_CODE=0xC000, write 0xFFFF with step 0 -> dac_value=0xC000 next edge, range_err=1. Next write of 0x9000 -> range_err=0.
- Retarget and priority: ramp to 0x9000, step 0x100; at dac_value=0x8300 write 0x8000 coincident with a tick -> tick dropped, RAMP_DOWN, next change 0x8200 RATE_DIV later.
- estop mid-ramp: assert during RAMP_UP with a simultaneous write -> dac_value=0x8000 next edge, write ignored. Deassert -> IDLE, at_target=1, dac_value unchanged.

Source files
------------

// File: rtl/oop_dac_ramp.sv
// rtl/oop_dac_ramp.sv - slew-limited setpoint sequencer for the OOP cathode DAC
module oop_dac_ramp #(
    parameter int unsigned RATE_DIV   = 32768,
    parameter logic [15:0] MIN_CODE   = 16'h0000,
    parameter logic [15:0] MAX_CODE   = 16'hFFFF,
    parameter logic [15:0] SAFE_VALUE = 16'h8000
) (
    input  logic        clk48mhz,
    input  logic        rstn,
    input  logic [15:0] target_value,
    input  logic [15:0] step_size,
    input  logic        target_wr,
    input  logic        estop,
    output logic [15:0] dac_value,
    output logic        busy,
    output logic        at_target,
    output logic        range_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RAMP_UP,
        ST_RAMP_DOWN,
        ST_SAFE
    } state_t;

    // Counter is wide enough for the largest legal divider; a tick is the last count.
    localparam logic [23:0] TICK_LAST = 24'(RATE_DIV - 1);

    state_t      state, state_n;
    logic [15:0] target_reg, target_n;
    logic [15:0] step_reg, step_n;
    logic [15:0] dac_n;
    logic [23:0] tick_cnt, tick_n;
    logic        busy_n, at_target_n, range_err_n;

    logic [15:0] clamped_target;
    logic        clamp_hit;
    logic [16:0] over_max_diff;
    logic [16:0] under_min_diff;
    logic [16:0] up_diff;
    logic [16:0] down_diff;
    logic        tick;

    // Clamp the requested code; the borrow bit of a 17-bit subtraction flags out-of-range.
    always_comb begin
        over_max_diff  = {1'b0, MAX_CODE} - {1'b0, target_value};
        under_min_diff = {1'b0, target_value} - {1'b0, MIN_CODE};
        clamped_target = target_value;
        clamp_hit      = 1'b0;
        if (over_max_diff[16]) begin
            clamped_target = MAX_CODE;
            clamp_hit      = 1'b1;
        end else if (under_min_diff[16]) begin
            clamped_target = MIN_CODE;
            clamp_hit      = 1'b1;
        end
    end

    // Remaining distance to the target in each direction, wide enough that it never wraps.
    always_comb begin
        up_diff   = {1'b0, target_reg} - {1'b0, dac_value};
        down_diff = {1'b0, dac_value} - {1'b0, target_reg};
        tick      = (tick_cnt == TICK_LAST);
    end

    // Next-state and next-output logic: estop beats a write, a write beats a tick.
    always_comb begin
        state_n     = state;
        target_n    = target_reg;
        step_n      = step_reg;
        dac_n       = dac_value;
        tick_n      = tick_cnt;
        range_err_n = range_err;

        if (estop) begin
            state_n  = ST_SAFE;
            dac_n    = SAFE_VALUE;
            target_n = SAFE_VALUE;
            tick_n   = 24'd0;
        end else if (state == ST_SAFE) begin
            // Leaving estop parks on the safe code until the host writes again.
            state_n  = ST_IDLE;
            target_n = SAFE_VALUE;
            tick_n   = 24'd0;
        end else if (target_wr) begin
            target_n    = clamped_target;
            step_n      = step_size;
            tick_n      = 24'd0;
            range_err_n = clamp_hit;
            if (step_size == 16'd0) begin
                dac_n   = clamped_target;
                state_n = ST_IDLE;
            end else if (clamped_target > dac_value) begin
                state_n = ST_RAMP_UP;
            end else if (clamped_target < dac_value) begin
                state_n = ST_RAMP_DOWN;
            end else begin
                state_n = ST_IDLE;
            end
        end else begin
            case (state)
                ST_RAMP_UP: begin
                    if (tick) begin
                        tick_n = 24'd0;
                        if (up_diff <= {1'b0, step_reg}) begin
                            dac_n   = target_reg;
                            state_n = ST_IDLE;
                        end else begin
                            dac_n = dac_value + step_reg;
                        end
                    end else begin
                        tick_n = tick_cnt + 24'd1;
                    end
                end
                ST_RAMP_DOWN: begin
                    if (tick) begin
                        tick_n = 24'd0;
                        if (down_diff <= {1'b0, step_reg}) begin
                            dac_n   = target_reg;
                            state_n = ST_IDLE;
                        end else begin
                            dac_n = dac_value - step_reg;
                        end
                    end else begin
                        tick_n = tick_cnt + 24'd1;
                    end
                end
                default: begin
                    tick_n = 24'd0;
                end
            endcase
        end

        busy_n      = (state_n == ST_RAMP_UP) || (state_n == ST_RAMP_DOWN);
        at_target_n = (state_n == ST_IDLE);
    end

    // State and output registers; reset returns everything to the safe parked condition.
    always_ff @(posedge clk48mhz) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            dac_value  <= SAFE_VALUE;
            target_reg <= SAFE_VALUE;
            step_reg   <= 16'd0;
            tick_cnt   <= 24'd0;
            busy       <= 1'b0;
            at_target  <= 1'b1;
            range_err  <= 1'b0;
        end else begin
            state      <= state_n;
            dac_value  <= dac_n;
            target_reg <= target_n;
            step_reg   <= step_n;
            tick_cnt   <= tick_n;
            busy       <= busy_n;
            at_target  <= at_target_n;
            range_err  <= range_err_n;
        end
    end

endmodule
